// File: rtl/rs_encoder.sv
// -----------------------------------------------------------------------------
// rs_encoder
//
// Systematic Reed-Solomon (7,3) encoder over GF(2^3), p(x) = x^3 + x + 1,
// alpha = 3'd2, generator g(x) = x^4 + 3x^3 + 1x^2 + 2x + 3 (corrects t = 2
// symbol errors). A 9-bit message is accepted over a valid/ready handshake.
// Its three symbols are shifted through a 4-stage symbol-serial LFSR, one per
// cycle and highest degree first. The packed 21-bit codeword is then held
// until the downstream block takes it.
//
// Ports
//   clk        in   1  single clock, rising edge
//   reset      in   1  asynchronous, active-low; clears all state
//   msg_valid  in   1  msg holds a message to encode
//   msg_ready  out  1  encoder idle and able to accept (registered)
//   msg        in   9  {m2, m1, m0}, m2 = highest degree
//   cw_valid   out  1  codeword valid (registered)
//   cw_ready   in   1  downstream accepts the codeword
//   codeword   out 21  {c6..c0} = {m2, m1, m0, p3, p2, p1, p0} (registered)
//   cw_count   out  8  number of codewords handed off, wraps 255 -> 0
// -----------------------------------------------------------------------------
module rs_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [8:0]  msg,
  output logic        cw_valid,
  input  logic        cw_ready,
  output logic [20:0] codeword,
  output logic [7:0]  cw_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Constant multiply by alpha (x): shift left and fold x^3 back as x + 1.
  function automatic logic [2:0] gf_mul2(input logic [2:0] a);
    return {a[1], a[0] ^ a[2], a[2]};
  endfunction

  // Constant multiply by alpha^3 = x + 1, i.e. (a * x) + a.
  function automatic logic [2:0] gf_mul3(input logic [2:0] a);
    return gf_mul2(a) ^ a;
  endfunction

  state_t      state_r;
  state_t      next_state_s;

  logic [8:0]  msg_r;
  logic [1:0]  sc_r;
  logic [2:0]  r3_r;
  logic [2:0]  r2_r;
  logic [2:0]  r1_r;
  logic [2:0]  r0_r;

  logic        msg_ready_r;
  logic        cw_valid_r;
  logic [20:0] codeword_r;
  logic [7:0]  cw_count_r;

  logic        accept_s;
  logic        handoff_s;
  logic [2:0]  sym_s;
  logic [2:0]  fb_s;
  logic [2:0]  r3_nx_s;
  logic [2:0]  r2_nx_s;
  logic [2:0]  r1_nx_s;
  logic [2:0]  r0_nx_s;

  // Handshake qualifiers. msg_ready_r is high only in IDLE and cw_valid_r only
  // in DONE, so these also encode the state they belong to.
  always_comb begin
    accept_s  = msg_valid & msg_ready_r;
    handoff_s = cw_valid_r & cw_ready;
  end

  // Symbol select and LFSR next-state: m2 enters first, m0 last.
  always_comb begin
    sym_s = 3'd0;
    case (sc_r)
      2'd0:    sym_s = msg_r[8:6];
      2'd1:    sym_s = msg_r[5:3];
      2'd2:    sym_s = msg_r[2:0];
      default: sym_s = 3'd0;
    endcase
    fb_s    = sym_s ^ r3_r;
    r3_nx_s = r2_r ^ gf_mul3(fb_s);
    r2_nx_s = r1_r ^ fb_s;
    r1_nx_s = r0_r ^ gf_mul2(fb_s);
    r0_nx_s = gf_mul3(fb_s);
  end

  // FSM next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sc_r == 2'd2) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (handoff_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: message latch, LFSR, symbol counter and registered outputs.
  // The codeword register is loaded on the final shift edge from the LFSR
  // next-state, so cw_valid and codeword rise together and stay frozen in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_r       <= 9'd0;
      sc_r        <= 2'd0;
      r3_r        <= 3'd0;
      r2_r        <= 3'd0;
      r1_r        <= 3'd0;
      r0_r        <= 3'd0;
      msg_ready_r <= 1'b1;
      cw_valid_r  <= 1'b0;
      codeword_r  <= 21'd0;
      cw_count_r  <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            msg_r       <= msg;
            sc_r        <= 2'd0;
            r3_r        <= 3'd0;
            r2_r        <= 3'd0;
            r1_r        <= 3'd0;
            r0_r        <= 3'd0;
            msg_ready_r <= 1'b0;
          end else begin
            msg_ready_r <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r3_r <= r3_nx_s;
          r2_r <= r2_nx_s;
          r1_r <= r1_nx_s;
          r0_r <= r0_nx_s;
          sc_r <= sc_r + 2'd1;
          if (sc_r == 2'd2) begin
            cw_valid_r <= 1'b1;
            codeword_r <= {msg_r, r3_nx_s, r2_nx_s, r1_nx_s, r0_nx_s};
          end else begin
            cw_valid_r <= 1'b0;
          end
        end
        ST_DONE: begin
          if (handoff_s) begin
            cw_valid_r  <= 1'b0;
            msg_ready_r <= 1'b1;
            cw_count_r  <= cw_count_r + 8'd1;
          end else begin
            cw_valid_r  <= 1'b1;
          end
        end
        default: begin
          cw_valid_r  <= 1'b0;
          msg_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Output drive from registers only.
  always_comb begin
    msg_ready = msg_ready_r;
    cw_valid  = cw_valid_r;
    codeword  = codeword_r;
    cw_count  = cw_count_r;
  end

endmodule

// File: tb/tb_rs_encoder.sv
// -----------------------------------------------------------------------------
// tb_rs_encoder
//
// Directed self-checking bench for rs_encoder. Expected codewords come from
// hand-computed constants. Any other codeword is judged by a reference check:
// the top three symbols must equal the message, and the polynomial must
// vanish at alpha^1..alpha^4. Because the code is MDS, that check is enough to
// determine the codeword uniquely, and the same check recovers the message in
// the round-trip step.
// -----------------------------------------------------------------------------
module tb_rs_encoder;

  logic        clk;
  logic        reset;
  logic        msg_valid;
  logic        msg_ready;
  logic [8:0]  msg;
  logic        cw_valid;
  logic        cw_ready;
  logic [20:0] codeword;
  logic [7:0]  cw_count;

  int tests_run;
  int tests_failed;

  rs_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg       (msg),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .codeword  (codeword),
    .cw_count  (cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(8) multiply: shift-and-add with reduction by x^3 + x + 1.
  function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] p;
    logic [3:0] t;
    p = 3'd0;
    t = {1'b0, a};
    for (int i = 0; i < 3; i++) begin
      if (b[i]) p = p ^ t[2:0];
      t = {t[2:0], 1'b0};
      if (t[3]) t = t ^ 4'b1011;
    end
    return p;
  endfunction

  // 1 when c(x) evaluates to zero at alpha, alpha^2, alpha^3 and alpha^4.
  function automatic logic syn_ok(input logic [20:0] cw);
    logic [2:0]  beta;
    logic [2:0]  acc;
    logic        ok;
    ok   = 1'b1;
    beta = 3'd1;
    for (int j = 1; j <= 4; j++) begin
      beta = gmul(beta, 3'd2);
      acc  = 3'd0;
      for (int i = 6; i >= 0; i--) begin
        acc = gmul(acc, beta) ^ cw[3*i +: 3];
      end
      if (acc != 3'd0) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Offer one message and wait for cw_valid. lat = edges from accept to valid.
  task automatic run_msg(input logic [8:0] m, output logic [20:0] cw, output int lat);
    int n;
    n = 0;
    while (msg_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    msg       = m;
    msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    lat = 0;
    while (cw_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    cw = codeword;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    msg_valid = 1'b0;
    msg       = 9'd0;
    cw_ready  = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if (msg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_msg_ready got=%b exp=1", msg_ready);
    end
    tests_run++;
    if (cw_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cw_valid got=%b exp=0", cw_valid);
    end
    tests_run++;
    if (codeword !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_codeword got=%h exp=0", codeword);
    end
    tests_run++;
    if (cw_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_cw_count got=%0d exp=0", cw_count);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_known_vectors();
    logic [8:0]  msgs [4];
    logic [20:0] exps [4];
    logic [20:0] cw;
    int          lat;
    logic [7:0]  exp_count;
    msgs[0] = 9'b000_000_001; exps[0] = 21'b000_000_001_011_001_010_011;
    msgs[1] = 9'b000_000_010; exps[1] = 21'b000_000_010_110_010_100_110;
    msgs[2] = 9'b001_000_000; exps[2] = 21'b001_000_000_110_001_110_111;
    msgs[3] = 9'b000_000_000; exps[3] = 21'd0;
    exp_count = 8'd0;
    cw_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_msg(msgs[i], cw, lat);
      tests_run++;
      if (lat !== 3) begin
        tests_failed++;
        $display("FAIL known_latency[%0d] got=%0d exp=3", i, lat);
      end
      tests_run++;
      if (cw !== exps[i]) begin
        tests_failed++;
        $display("FAIL known_codeword[%0d] got=%b exp=%b", i, cw, exps[i]);
      end
      tests_run++;
      if (syn_ok(cw) !== 1'b1) begin
        tests_failed++;
        $display("FAIL known_syndrome[%0d] got=%b exp=1", i, syn_ok(cw));
      end
      tick();
      exp_count = exp_count + 8'd1;
      tests_run++;
      if (cw_count !== exp_count || msg_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL known_handoff[%0d] count got=%0d exp=%0d ready got=%b exp=1",
                 i, cw_count, exp_count, msg_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0]  m;
    logic [20:0] cw;
    int          lat;
    logic [7:0]  exp_count;
    do_reset();
    exp_count = 8'd0;
    m         = 9'b010_011_101;
    cw_ready  = 1'b0;
    run_msg(m, cw, lat);
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("FAIL bp_latency got=%0d exp=3", lat);
    end
    for (int c = 0; c < 10; c++) begin
      msg       = 9'($urandom_range(0, 511));
      msg_valid = ~msg_valid;
      tick();
      tests_run++;
      if (cw_valid !== 1'b1 || msg_ready !== 1'b0 || codeword[20:12] !== m ||
          syn_ok(codeword) !== 1'b1 || cw_count !== exp_count) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] valid=%b ready=%b cw=%b count=%0d exp valid=1 ready=0 msg=%b syn=1 count=%0d",
                 c, cw_valid, msg_ready, codeword, cw_count, m, exp_count);
      end
    end
    msg_valid = 1'b0;
    cw_ready  = 1'b1;
    tick();
    tests_run++;
    if (cw_count !== exp_count + 8'd1 || cw_valid !== 1'b0 || msg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release count=%0d exp=%0d valid=%b exp=0 ready=%b exp=1",
               cw_count, exp_count + 8'd1, cw_valid, msg_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  msgs [4];
    logic [20:0] got_cw [4];
    int          got_cyc [4];
    int          got;
    logic        prev;
    do_reset();
    msgs[0] = 9'b000_000_001;
    msgs[1] = 9'b111_111_111;
    msgs[2] = 9'b001_000_000;
    msgs[3] = 9'b101_010_110;
    got       = 0;
    prev      = 1'b0;
    cw_ready  = 1'b1;
    msg       = msgs[0];
    msg_valid = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (cw_valid === 1'b1 && !prev && got < 4) begin
        got_cw[got]  = codeword;
        got_cyc[got] = cyc;
        got++;
        if (got < 4) msg = msgs[got];
        else msg_valid = 1'b0;
      end
      prev = cw_valid;
    end
    msg_valid = 1'b0;
    tests_run++;
    if (got !== 4) begin
      tests_failed++;
      $display("FAIL b2b_handoffs got=%0d exp=4", got);
    end
    for (int i = 0; i < got; i++) begin
      tests_run++;
      if (got_cw[i][20:12] !== msgs[i] || syn_ok(got_cw[i]) !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_codeword[%0d] got=%b exp_msg=%b syn=%b exp=1",
                 i, got_cw[i], msgs[i], syn_ok(got_cw[i]));
      end
      if (i > 0) begin
        tests_run++;
        if (got_cyc[i] - got_cyc[i-1] !== 5) begin
          tests_failed++;
          $display("FAIL b2b_spacing[%0d] got=%0d exp=5", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
    tests_run++;
    if (got > 0 && got_cyc[0] !== 4) begin
      tests_failed++;
      $display("FAIL b2b_first_valid got=%0d exp=4", got_cyc[0]);
    end
    tests_run++;
    if (cw_count !== 8'd4) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d exp=4", cw_count);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [20:0] cw;
    int          lat;
    do_reset();
    cw_ready  = 1'b1;
    msg       = 9'b011_101_110;
    msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    tick();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if (msg_ready !== 1'b1 || cw_valid !== 1'b0 || cw_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL midrst_immediate ready=%b exp=1 valid=%b exp=0 count=%0d exp=0",
               msg_ready, cw_valid, cw_count);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      tests_run++;
      if (cw_valid !== 1'b0 || codeword !== 21'd0) begin
        tests_failed++;
        $display("FAIL midrst_hold[%0d] valid=%b exp=0 cw=%h exp=0", c, cw_valid, codeword);
      end
    end
    reset = 1'b1;
    run_msg(9'b001_000_000, cw, lat);
    tests_run++;
    if (lat !== 3 || cw !== 21'b001_000_000_110_001_110_111) begin
      tests_failed++;
      $display("FAIL midrst_fresh lat=%0d exp=3 cw=%b exp=%b",
               lat, cw, 21'b001_000_000_110_001_110_111);
    end
    tick();
    tests_run++;
    if (cw_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL midrst_count got=%0d exp=1", cw_count);
    end
  endtask

  task automatic test_wrap_random();
    logic [20:0] cw;
    logic [8:0]  m;
    int          lat;
    do_reset();
    cw_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      m = 9'($urandom_range(0, 511));
      run_msg(m, cw, lat);
      if (i <= 50) begin
        tests_run++;
        if (lat !== 3 || syn_ok(cw) !== 1'b1 || cw[20:12] !== m) begin
          tests_failed++;
          $display("FAIL rand[%0d] lat=%0d cw=%b syn=%b recovered=%b exp_msg=%b",
                   i, lat, cw, syn_ok(cw), cw[20:12], m);
        end
      end
      tick();
      if (i == 255) begin
        tests_run++;
        if (cw_count !== 8'd255) begin
          tests_failed++;
          $display("FAIL wrap_255 got=%0d exp=255", cw_count);
        end
      end
    end
    tests_run++;
    if (cw_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL wrap_0 got=%0d exp=0", cw_count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    test_wrap_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
